key_schedule_gen: RTL and testbench

KEY_SCHEDULE_GEN -- requirements
Module: key_schedule_gen

---
 rtl/key_schedule_gen.sv | 176 +++++++++++++++++
 tb/tb_key_schedule_gen.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/key_schedule_gen.sv
// rtl/key_schedule_gen.sv - AES-128/192/256 round-key generator, one 32-bit word per cycle
// Streams round keys 0..Nr over a valid/ready handshake from a sliding MAX_NK-word window.
module key_schedule_gen #(
  parameter int MAX_NK = 8
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_start,
  input  logic [1:0]   i_mode,
  input  logic [255:0] i_key_in,
  output logic         o_rk_valid,
  input  logic         i_rk_ready,
  output logic [127:0] o_rk_data,
  output logic [3:0]   o_rk_index,
  output logic         o_busy,
  output logic         o_done,
  output logic         o_err
);

  typedef enum logic [1:0] {S_IDLE, S_EXPAND, S_DONE} state_t;

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [2047:0] sh;
    sh = SBOX << {x, 3'b000};
    return sh[2047:2040];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [31:0] key_word(input logic [255:0] k, input logic [2:0] j);
    logic [255:0] sh;
    sh = k << {j, 5'b00000};
    return sh[255:224];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  state_t        r_state, w_state_nxt;
  logic [3:0]    r_nk, r_nr;
  logic [5:0]    r_last, r_i;
  logic [2:0]    r_mod;
  logic [7:0]    r_rcon;
  logic [31:0]   r_win [MAX_NK];
  logic          r_rk_valid, r_err;
  logic [127:0]  r_rk_data;
  logic [3:0]    r_rk_index;

  logic [3:0]    w_nk, w_nr;
  logic          w_illegal, w_accept, w_xfer, w_gen, w_load;
  logic          w_rot_case, w_sub_case, w_key_phase;
  logic [31:0]   w_prev, w_old, w_sub_in, w_sub_out, w_temp, w_new;

  always_comb begin
    w_nk = 4'd0;
    w_nr = 4'd0;
    case (i_mode)
      2'd0:    begin w_nk = 4'd4; w_nr = 4'd10; end
      2'd1:    begin w_nk = 4'd6; w_nr = 4'd12; end
      2'd2:    begin w_nk = 4'd8; w_nr = 4'd14; end
      default: begin w_nk = 4'd0; w_nr = 4'd0;  end
    endcase
  end

  assign w_illegal = (i_mode == 2'd3) || (32'(w_nk) > MAX_NK);
  assign w_accept  = (r_state == S_IDLE) && i_start && !w_illegal;
  assign w_xfer    = r_rk_valid && i_rk_ready;
  assign w_gen     = (r_state == S_EXPAND) && !(r_rk_valid && !i_rk_ready) && (r_i <= r_last);
  assign w_load    = w_gen && (r_i[1:0] == 2'b11);

  always_comb begin
    w_old = r_win[0];
    for (int j = 0; j < MAX_NK; j++) begin
      if (4'(j) == r_nk - 4'd1) w_old = r_win[j];
    end
  end

  // While i < Nk the preloaded window rotates, so w[i-Nk] is already key word i.
  assign w_key_phase = r_i < {2'b00, r_nk};
  assign w_rot_case  = !w_key_phase && (r_mod == 3'd0);
  assign w_sub_case  = !w_key_phase && (r_nk == 4'd8) && (r_mod == 3'd4);
  assign w_prev      = r_win[0];
  assign w_sub_in    = w_rot_case ? {w_prev[23:0], w_prev[31:24]} : w_prev;
  assign w_sub_out   = sub_word(w_sub_in);

  always_comb begin
    w_temp = w_prev;
    if (w_key_phase)     w_temp = 32'h0;
    else if (w_rot_case) w_temp = w_sub_out ^ {r_rcon, 24'h0};
    else if (w_sub_case) w_temp = w_sub_out;
  end

  assign w_new = w_old ^ w_temp;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_accept) w_state_nxt = S_EXPAND;
      S_EXPAND: if (w_xfer && (r_rk_index == r_nr)) w_state_nxt = S_DONE;
      S_DONE:   w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_nk       <= '0;
      r_nr       <= '0;
      r_last     <= '0;
      r_i        <= '0;
      r_mod      <= '0;
      r_rcon     <= '0;
      r_rk_valid <= 1'b0;
      r_rk_data  <= '0;
      r_rk_index <= '0;
      r_err      <= 1'b0;
      for (int j = 0; j < MAX_NK; j++) r_win[j] <= '0;
    end else begin
      r_err <= (r_state == S_IDLE) && i_start && w_illegal;
      if (w_accept) begin
        r_nk   <= w_nk;
        r_nr   <= w_nr;
        r_last <= {w_nr, 2'b11};
        r_i    <= '0;
        r_mod  <= '0;
        r_rcon <= 8'h01;
        // Slot Nk-1 holds key word 0 so the first Nk cycles emit the key in order.
        for (int s = 0; s < MAX_NK; s++) begin
          if (s < int'(w_nk)) r_win[s] <= key_word(i_key_in, 3'(int'(w_nk) - 1 - s));
          else                r_win[s] <= '0;
        end
      end else begin
        if (w_xfer) r_rk_valid <= 1'b0;
        if (w_gen) begin
          r_win[0] <= w_new;
          for (int j = 1; j < MAX_NK; j++) r_win[j] <= r_win[j-1];
          r_i   <= r_i + 6'd1;
          r_mod <= ({1'b0, r_mod} == r_nk - 4'd1) ? 3'd0 : r_mod + 3'd1;
          if (w_rot_case) r_rcon <= xtime(r_rcon);
        end
        if (w_load) begin
          r_rk_data  <= {r_win[2], r_win[1], r_win[0], w_new};
          r_rk_index <= r_i[5:2];
          r_rk_valid <= 1'b1;
        end
      end
    end
  end

  assign o_rk_valid = r_rk_valid;
  assign o_rk_data  = r_rk_data;
  assign o_rk_index = r_rk_index;
  assign o_busy     = (r_state == S_EXPAND);
  assign o_done     = (r_state == S_DONE);
  assign o_err      = r_err;

endmodule

// File: tb/tb_key_schedule_gen.sv
// tb/tb_key_schedule_gen.sv - directed, table-driven bench for key_schedule_gen
// FIPS-197 key expansion vectors, backpressure, reject/ignore and mid-run reset sequences.
module tb_key_schedule_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset, start, rk_ready;
  logic [1:0]   mode;
  logic [255:0] key_in;
  logic         rk_valid, busy, done, err;
  logic [127:0] rk_data;
  logic [3:0]   rk_index;

  logic         s4_start;
  logic [1:0]   s4_mode;
  logic         v4, b4, d4, e4;
  logic [127:0] dat4;
  logic [3:0]   idx4;

  key_schedule_gen dut (
    .i_clk(clk), .i_reset(reset), .i_start(start), .i_mode(mode), .i_key_in(key_in),
    .o_rk_valid(rk_valid), .i_rk_ready(rk_ready), .o_rk_data(rk_data), .o_rk_index(rk_index),
    .o_busy(busy), .o_done(done), .o_err(err)
  );

  key_schedule_gen #(.MAX_NK(4)) dut4 (
    .i_clk(clk), .i_reset(reset), .i_start(s4_start), .i_mode(s4_mode), .i_key_in(key_in),
    .o_rk_valid(v4), .i_rk_ready(rk_ready), .o_rk_data(dat4), .o_rk_index(idx4),
    .o_busy(b4), .o_done(d4), .o_err(e4)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0]   mode;
    logic [255:0] key;
    logic [127:0] r0;
    logic [127:0] rlast;
    int           ncap;
    int           done_cyc;
    bit           poke;
  } vec_t;

  vec_t         vecs [3];
  logic [127:0] aes128_rk [11];

  logic [127:0] cap_data [16];
  logic [3:0]   cap_idx  [16];
  int           cap_cyc  [16];
  int           n_cap, done_cyc, stall_bad, busy_bad, err_bad;

  // Launches one expansion at the next edge (edge 0) and logs every transfer until done.
  task automatic do_run(input logic [1:0] m, input logic [255:0] k, input int pct,
                        input bit poke, input int budget);
    int cyc;
    bit held;
    logic [127:0] hd;
    logic [3:0] hi;
    mode = m; key_in = k; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; key_in = ~k; mode = ~m;
    n_cap = 0; done_cyc = -1; stall_bad = 0; busy_bad = 0; err_bad = 0;
    held = 1'b0; hd = '0; hi = '0; cyc = 0;
    rk_ready = (pct >= 100) ? 1'b1 : ($urandom_range(0, 99) < pct);
    while (cyc < budget && done_cyc < 0) begin
      @(negedge clk);
      if (err) err_bad++;
      if (done) done_cyc = cyc;
      else begin
        if (!busy) busy_bad++;
        if (held && (!rk_valid || rk_data !== hd || rk_index !== hi)) stall_bad++;
        held = 1'b0;
        if (rk_valid) begin
          if (rk_ready) begin
            if (n_cap < 16) begin
              cap_data[n_cap] = rk_data; cap_idx[n_cap] = rk_index; cap_cyc[n_cap] = cyc;
            end
            n_cap++;
          end else begin
            held = 1'b1; hd = rk_data; hi = rk_index;
          end
        end
      end
      @(posedge clk); #1;
      cyc++;
      rk_ready = (pct >= 100) ? 1'b1 : ($urandom_range(0, 99) < pct);
      start = poke && (cyc == 10);
      if (start) begin mode = 2'd0; key_in = '1; end
    end
    start = 1'b0; rk_ready = 1'b1;
  endtask

  task automatic check_run(input string n, input logic [127:0] r0, input logic [127:0] rlast,
                           input int ncap, input int dexp);
    int bad;
    bad = 0;
    for (int j = 0; j < n_cap && j < 16; j++) if (cap_idx[j] !== 4'(j)) bad++;
    chk({n, "_transfers"}, n_cap, ncap);
    chk({n, "_index_seq"}, bad, 0);
    chk({n, "_round0"}, cap_data[0], r0);
    chk({n, "_round_last"}, cap_data[ncap-1], rlast);
    chk({n, "_stall_stable"}, stall_bad, 0);
    chk({n, "_busy_during"}, busy_bad, 0);
    chk({n, "_no_err"}, err_bad, 0);
    if (dexp >= 0) begin
      chk({n, "_done_edge"}, done_cyc, dexp);
      chk({n, "_last_valid_edge"}, cap_cyc[ncap-1], dexp - 1);
    end else begin
      chk({n, "_done_seen"}, done_cyc >= 0, 1);
    end
    chk({n, "_done_pulse_1cyc"}, done, 0);
    chk({n, "_busy_after"}, busy, 0);
  endtask

  initial begin
    bit found;
    int cnt;

    aes128_rk[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    aes128_rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    aes128_rk[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    aes128_rk[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    aes128_rk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    aes128_rk[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    aes128_rk[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    aes128_rk[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    aes128_rk[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    aes128_rk[9]  = 128'hac7766f319fadc2128d12941575c006e;
    aes128_rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    vecs[0] = '{2'd0, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'hdeadbeef0123456789abcdef55aa55aa},
                128'h2b7e151628aed2a6abf7158809cf4f3c, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 11, 45, 1'b0};
    vecs[1] = '{2'd1, {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'hffffffffffffffff},
                128'h8e73b0f7da0e6452c810f32b809079e5, 128'he98ba06f448c773c8ecc720401002202, 13, 53, 1'b1};
    vecs[2] = '{2'd2, 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4,
                128'h603deb1015ca71be2b73aef0857d7781, 128'hfe4890d1e6188d0b046df344706c631e, 15, 61, 1'b0};

    reset = 1'b0; start = 1'b0; mode = 2'd0; key_in = '0; rk_ready = 1'b1;
    s4_start = 1'b0; s4_mode = 2'd0;
    #22;
    chk("reset_rk_valid", rk_valid, 0);
    chk("reset_rk_data", rk_data, 0);
    chk("reset_rk_index", rk_index, 0);
    chk("reset_busy_done_err", {busy, done, err}, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;

    for (int v = 0; v < 3; v++) begin
      do_run(vecs[v].mode, vecs[v].key, 100, vecs[v].poke, 200);
      check_run($sformatf("vec%0d", v), vecs[v].r0, vecs[v].rlast, vecs[v].ncap, vecs[v].done_cyc);
    end

    do_run(2'd0, vecs[0].key, 30, 1'b0, 2000);
    check_run("aes128_backpressure", aes128_rk[0], aes128_rk[10], 11, -1);
    for (int r = 0; r < 11; r++) chk($sformatf("bp_round%0d", r), cap_data[r], aes128_rk[r]);

    mode = 2'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("illegal_err_pulse", err, 1);
    chk("illegal_busy", busy, 0);
    chk("illegal_rk_valid", rk_valid, 0);
    @(posedge clk); #1;
    chk("illegal_err_one_cycle", err, 0);
    cnt = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (rk_valid || busy) cnt++;
    end
    chk("illegal_stays_idle", cnt, 0);
    @(posedge clk); #1;

    s4_mode = 2'd2; s4_start = 1'b1;
    @(posedge clk); #1;
    s4_start = 1'b0;
    chk("maxnk4_mode2_err", e4, 1);
    chk("maxnk4_mode2_busy", b4, 0);
    s4_mode = 2'd0; s4_start = 1'b1;
    @(posedge clk); #1;
    s4_start = 1'b0;
    chk("maxnk4_mode0_err", e4, 0);
    chk("maxnk4_mode0_busy", b4, 1);

    mode = 2'd2; key_in = vecs[2].key; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      @(negedge clk);
      if (rk_valid && rk_ready && rk_index == 4'd3) found = 1'b1;
      @(posedge clk); #1;
    end
    chk("midreset_round3_seen", found, 1);
    reset = 1'b0;
    #1;
    chk("midreset_rk_valid", rk_valid, 0);
    chk("midreset_rk_data", rk_data, 0);
    chk("midreset_rk_index", rk_index, 0);
    chk("midreset_busy_done_err", {busy, done, err}, 0);
    cnt = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (done || busy || rk_valid) cnt++;
    end
    chk("midreset_held_quiet", cnt, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    do_run(2'd0, vecs[0].key, 100, 1'b0, 200);
    check_run("after_reset", aes128_rk[0], aes128_rk[10], 11, 45);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
